// File: rtl/wb_pkg.sv
// Shared widths and the queued write-back entry type for the write-back stage.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// ALU-result queue: wrap-around pointers plus an occupancy count, active-low sync reset.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr_reg] <= push_entry;
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back arbiter: load results win, queued ALU results fill idle slots; tracks pending registers.
// Optional WB_ZERO_GUARD_EN: results and issues targeting r0 are consumed without effect.
module wb_stage
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0]     write_data,
  output logic [NUM_REGS-1:0]   pending,
  output logic                  issue_err
);
  wb_entry_t                    head;
  wb_entry_t                    sel;
  logic                         full;
  logic                         empty;
  logic [$clog2(FIFO_DEPTH):0]  count;
  logic                         push;
  logic                         pop;
  logic                         launch;
  logic                         do_write;
  logic                         set_en;
  logic                         reg_write_reg;
  logic [REG_ADDR_W-1:0]        write_register_reg;
  logic [DATA_W-1:0]            write_data_reg;
  logic [NUM_REGS-1:0]          pending_reg;
  logic [NUM_REGS-1:0]          pending_next;
  logic                         issue_err_reg;
  logic                         issue_err_next;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{rd: alu_rd, data: alu_data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  assign alu_ready = !full;
  assign push      = alu_valid && alu_ready;
  assign pop       = !mem_valid && !empty;
  assign launch    = mem_valid || (count != '0);

  always_comb begin
    sel = head;
    if (mem_valid) sel = '{rd: mem_rd, data: mem_data};
`ifdef WB_ZERO_GUARD_EN
    do_write = launch && (sel.rd != '0);
    set_en   = issue_valid && (issue_rd != '0);
`else
    do_write = launch;
    set_en   = issue_valid;
`endif
  end

  // Set is applied after clear so a same-edge issue keeps the bit outstanding.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
    always_comb begin
      pending_next[gi] = (set_en && (issue_rd == REG_ADDR_W'(gi))) ||
                         (pending_reg[gi] && !(do_write && (sel.rd == REG_ADDR_W'(gi))));
    end
  end

  assign issue_err_next = issue_err_reg || (set_en && pending_reg[issue_rd]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_write_reg      <= 1'b0;
      write_register_reg <= '0;
      write_data_reg     <= '0;
      pending_reg        <= '0;
      issue_err_reg      <= 1'b0;
    end else begin
      reg_write_reg <= do_write;
      if (do_write) begin
        write_register_reg <= sel.rd;
        write_data_reg     <= sel.data;
      end
      pending_reg   <= pending_next;
      issue_err_reg <= issue_err_next;
    end
  end

  assign RegWrite       = reg_write_reg;
  assign write_register = write_register_reg;
  assign write_data     = write_data_reg;
  assign pending        = pending_reg;
  assign issue_err      = issue_err_reg;
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, ALU-result queue depth (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port alu_valid  input  1  ALU result offered.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port alu_data  input  32  ALU result.
REQ-007 SHALL have port alu_ready  output  1  queue can accept ALU result.
REQ-008 SHALL have port mem_valid  input  1  load result offered; always accepted.
REQ-009 SHALL have port mem_rd  input  5  load destination register.
REQ-010 SHALL have port mem_data  input  32  load data.
REQ-011 SHALL have port issue_valid  input  1  decode issues instruction with destination.
REQ-012 SHALL have port issue_rd  input  5  destination being issued.
REQ-013 SHALL have port RegWrite  output  1  register-bank write enable, registered.
REQ-014 SHALL have port write_register  output  5  register-bank write address, registered.
REQ-015 SHALL have port write_data  output  32  register-bank write data, registered.
REQ-016 SHALL have port pending  output  32  scoreboard; bit n = result for rn outstanding.
REQ-017 SHALL have port issue_err  output  1  sticky protocol-error flag.

Function
REQ-018 ALU handshake: transfer on alu_valid && alu_ready; alu_ready = queue count < FIFO_DEPTH, from registered count only (full with same-cycle pop stays not-ready).
REQ-019 Per edge at most one write is driven: mem_valid wins; otherwise queue head pops if non-empty; otherwise RegWrite goes 0.
REQ-020 Load latency: mem accepted at edge E -> RegWrite/write_register/write_data valid for the cycle after E.
REQ-021 ALU latency: entry pushed at edge E pops no earlier than edge E+1 (RegWrite earliest after E+1); no bypass.
REQ-022 Queue: FIFO order, wrap-around pointers of log2(FIFO_DEPTH) bits plus count 0..FIFO_DEPTH; simultaneous push and pop keeps count.
REQ-023 write_register/write_data hold last value when RegWrite is 0.
REQ-024 Scoreboard: issue_valid sets pending[issue_rd]; each write driven to the bank clears pending[write_register] at the same edge as it is launched.
REQ-025 Simultaneous set and clear of the same bit: set wins.
REQ-026 issue_valid with pending[issue_rd] already 1 SHALL set issue_err (sticky until reset); pending stays 1.
REQ-027 Results to a register whose pending bit is 0 are still written; no error.

Reset
REQ-028 While reset is low at a posedge: queue empty (count 0), pending = 0, RegWrite = 0, write_register = 0, write_data = 0, issue_err = 0; alu_ready = 1 from the first cycle after reset.
REQ-029 Reset mid-operation discards queued ALU results and a concurrent mem result; no write is launched at that edge.

Configuration
REQ-030 Macro WB_ZERO_GUARD_EN: when defined, results with destination 0 are consumed (mem accepted/queue popped) but RegWrite stays 0 and pending[0] is never set; when undefined, destination 0 is written like any register.

Structure
REQ-031 Shared package SHALL hold REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32 and the wb_entry_t typedef {rd, data}.
REQ-032 Queue SHALL be sub-module wb_fifo (parameterised depth, push/pop/full/empty/count).

Verification
REQ-033 Reset low, then one ALU result rd=5, data=0x0000_00AA -> RegWrite=1, write_register=5, write_data=0xAA two cycles after acceptance; pending[5] cleared.
REQ-034 mem_valid rd=3, data=0x1234_5678 and alu_valid rd=7, data=0x9 in same cycle -> r3 write in next cycle, r7 write one cycle later.
REQ-035 Hold mem_valid for 6 cycles while pushing 5 ALU results -> alu_ready drops after 4th push; 5th accepted after first pop; order preserved.
REQ-036 issue_rd=9 twice with no intervening write -> issue_err=1, stays 1 until reset.
REQ-037 issue_rd=4 in same cycle as write launched for r4 -> pending[4]=1 afterwards.
REQ-038 With WB_ZERO_GUARD_EN, mem result rd=0 -> RegWrite stays 0 and mem accepted; without the macro -> RegWrite=1, write_register=0.
